// File: rtl/fa32_adder_pkg.sv
// Shared datapath constants: default machine word width and the PC increment.
package fa32_adder_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

endpackage

// File: rtl/fa32_adder_full_adder_cell.sv
// One-bit full-adder cell; the basic element of the ripple carry chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/fa32_adder.sv
// WIDTH-bit ripple-carry adder with combinational sum/carry/overflow and an
// enabled, asynchronously reset registered copy for later pipeline stages.
module fa32_adder
    import fa32_adder_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             en,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q
);

    // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];
    assign ovf  = carry[WIDTH] ^ carry[WIDTH-1];

    // NOTE: state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (en) begin
            sum_q  <= sum;
            cout_q <= cout;
            ovf_q  <= ovf;
        end
    end

endmodule

// File: tb/tb_fa32_adder.sv
// Self-checking bench for fa32_adder: arithmetic reference model plus directed vectors.
module tb_fa32_adder;
    import fa32_adder_pkg::*;

    localparam int W = XLEN;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] sum, sum_q;
    logic         cout, ovf, cout_q, ovf_q;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    always #5 clk = ~clk;

    fa32_adder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .en     (en),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf),
        .sum_q  (sum_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    // Returns {ovf, cout, sum} from plain wide arithmetic and the sign rule.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        logic [W:0] t;
        logic       o;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {o, t};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected registered outputs.
    logic [W+1:0] exp_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)  exp_q <= '0;
        else if (en) exp_q <= ref_add(a, b, cin);
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            logic [W+1:0] e;
            e = ref_add(a, b, cin);
            check("sum",    64'(sum),    64'(e[W-1:0]));
            check("cout",   64'(cout),   64'(e[W]));
            check("ovf",    64'(ovf),    64'(e[W+1]));
            check("sum_q",  64'(sum_q),  64'(exp_q[W-1:0]));
            check("cout_q", 64'(cout_q), 64'(exp_q[W]));
            check("ovf_q",  64'(ovf_q),  64'(exp_q[W+1]));
        end
    end

    vec_t vecs[6] = '{
        '{32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0000_0004, 1'b0, 1'b0},
        '{32'hFFFF_FFFC, 32'h0000_0004, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
        '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
        '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1},
        '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0},
        '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0}
    };

    logic [W-1:0] corners[5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

    initial begin
        // Reset state and combinational path during reset.
        #1 rst_n = 1'b0;
        #1;
        check("rst_sum_q",  64'(sum_q),  64'h0);
        check("rst_cout_q", 64'(cout_q), 64'h0);
        check("rst_ovf_q",  64'(ovf_q),  64'h0);
        a = PC_INC;
        b = 32'h1;
        en = 1'b1;
        #1 check("rst_comb_sum", 64'(sum), 64'h5);
        cmp_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("rst_edge_ignored", 64'(sum_q), 64'h0);
        #2 rst_n = 1'b1;

        // Directed vectors with hand-computed results.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                check("dir_sum_q",  64'(sum_q),  64'(vecs[i-1].s));
                check("dir_cout_q", 64'(cout_q), 64'(vecs[i-1].co));
                check("dir_ovf_q",  64'(ovf_q),  64'(vecs[i-1].ov));
            end
            a = vecs[i].a;
            b = vecs[i].b;
            cin = vecs[i].cin;
            #1;
            check("dir_sum",  64'(sum),  64'(vecs[i].s));
            check("dir_cout", 64'(cout), 64'(vecs[i].co));
            check("dir_ovf",  64'(ovf),  64'(vecs[i].ov));
        end
        @(posedge clk);
        #1 check("dir_last_sum_q", 64'(sum_q), 64'(vecs[5].s));

        // Hold with en=0 while inputs change.
        a = 32'h1234_5678;
        b = 32'h0;
        cin = 1'b0;
        @(posedge clk);
        #1 en = 1'b0;
        check("hold_load", 64'(sum_q), 64'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            a = $urandom;
            b = $urandom;
            #1 check("hold_sum_q", 64'(sum_q), 64'h1234_5678);
        end

        // Mid-stream reset pulse between edges.
        @(posedge clk);
        #1;
        en = 1'b1;
        a = 32'd1;
        b = 32'd2;
        @(posedge clk);
        #1;
        check("pre_rst_sum_q", 64'(sum_q), 64'd3);
        a = 32'd10;
        b = 32'd20;
        #2 rst_n = 1'b0;
        #1 check("async_clear", 64'(sum_q), 64'h0);
        @(posedge clk);
        #1 check("edge_in_reset", 64'(sum_q), 64'h0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_rst_load", 64'(sum_q), 64'd30);

        // Randomised vectors biased to corner operands.
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            a   = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            b   = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            cin = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 7) != 0);
        end
        @(posedge clk);
        @(negedge clk);
        #1 cmp_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
